pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Parametrised program-counter generator for the fetch stage of the RV64I core.
- Holds the fetch PC and issues fetch requests to instruction memory with a valid/ready handshake.
- Records every issued PC in an in-order in-flight queue. Each memory response is tagged with the PC that produced it.
- On redirect (branch or jump), the PC is retargeted and all queued requests are marked stale, so the responses they later produce are dropped.

Parameters:
- XLEN, 64: PC and address width in bits.
- RESET_VECTOR, 0: PC value loaded on reset (XLEN bits).
- INST_BYTES, 4: PC increment per issued fetch.
- DEPTH, 4: maximum outstanding fetches; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- stall  in  1  freeze the PC and block new requests.
- redirect_valid  in  1  load redirect_pc this cycle.
- redirect_pc  in  XLEN  new fetch target.
- req_valid  out  1  fetch request valid.
- req_addr  out  XLEN  fetch address; equals current_pc.
- req_ready  in  1  memory accepts the request.
- rsp_valid  in  1  memory returns one in-order response.
- rsp_pc_valid  out  1  the response belongs to the live path.
- rsp_pc  out  XLEN  PC associated with the response (queue head PC).
- current_pc  out  XLEN  architectural fetch PC.
- inflight_cnt  out  clog2(DEPTH)+1  number of outstanding requests.
- misaligned  out  1  redirect_pc is not a multiple of INST_BYTES (combinational, qualified by redirect_valid).
- protocol_err  out  1  sticky; set by rsp_valid while the queue is empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - current_pc = RESET_VECTOR; queue empty; inflight_cnt = 0; all stale bits 0; protocol_err = 0.
  - req_valid = 0 and rsp_pc_valid = 0 while rst_n is low.
- req_valid = !stall && !redirect_valid && (inflight_cnt < DEPTH). This is combinational and has no dependency on req_ready.
- Issue event: fire = req_valid && req_ready.
  - The pair {current_pc, stale=0} is pushed at the tail.
  - current_pc <= current_pc + INST_BYTES, modulo 2^XLEN; wrap-around from all-ones is permitted.
- Stall:
  - current_pc holds.
  - No push occurs.
  - Responses are still accepted and popped.
- Redirect has the highest priority and acts even while stall is high.
  - current_pc <= redirect_pc, with no masking of low bits.
  - Every queue entry's stale bit is set to 1.
  - No push occurs in the redirect cycle.
- Response event (rsp_valid with a non-empty queue):
  - The head entry is popped in the same cycle.
  - rsp_pc = head PC, combinational from the head.
  - rsp_pc_valid = rsp_valid && !head_stale && !redirect_valid. A redirect in the same cycle kills the response.
  - Zero-cycle latency from rsp_valid to rsp_pc_valid.
- Response with an empty queue: no pop, rsp_pc_valid = 0, protocol_err is set and stays set until reset.
- Push and pop in the same cycle: inflight_cnt is unchanged and pointers advance independently.
- Full queue (inflight_cnt == DEPTH): req_valid = 0, even if a pop occurs in the same cycle. This conservative rule keeps req_valid free of any dependency on rsp_valid.
- Stale entries occupy queue slots until their responses arrive. After a redirect, new requests issue only while free slots exist.
- The output of rsp_pc when rsp_valid = 0 is don't-care; the bench must not check it.

Decomposition:
- Package pc_fetch_pkg holds:
  - default constants XLEN_DEF=64, RESET_VECTOR_DEF=0, INST_BYTES_DEF=4;
  - a typedef for the queue entry struct {pc[XLEN], stale}.
- Sub-module pc_inflight_fifo implements the DEPTH-entry circular buffer:
  - read/write pointers with a wrap bit;
  - a count output;
  - a "mark all stale" input;
  - a combinational head output.
- The top level contains the PC register, the next-PC mux (redirect > increment > hold) and the handshake logic.

Test Plan:
1. Reset, req_ready=1, no stall, respond 2 cycles after each request -> req_addr sequence 0x0, 0x4, 0x8, 0xC; rsp_pc matches the same order with rsp_pc_valid=1; inflight_cnt never exceeds DEPTH.
2. Stall high for 3 cycles at current_pc=0x10 -> req_valid=0, current_pc stays 0x10; a pending response for 0xC is still delivered with rsp_pc_valid=1.
3. Issue 0x0, 0x4, 0x8, then redirect_pc=0x100 -> current_pc=0x100 next cycle; the 3 following responses give rsp_pc_valid=0; the next request goes to 0x100 and its response gives rsp_pc_valid=1, rsp_pc=0x100.
4. req_ready=1, no responses -> exactly DEPTH=4 fires, then req_valid=0 with current_pc=0x10; one response -> req_valid reasserts the following cycle.
5. redirect_valid and rsp_valid in the same cycle for live entry 0x4 -> rsp_pc_valid=0, entry popped, remaining entries stale. Then rsp_valid with an empty queue -> protocol_err=1 and stays set.
6. rst_n asserted asynchronously mid-cycle with 3 entries in flight -> current_pc=RESET_VECTOR immediately; inflight_cnt=0, protocol_err=0; after release, fetch restarts at RESET_VECTOR. Also with RESET_VECTOR=0xFFFF_FFFF_FFFF_FFFC: one fire wraps current_pc to 0x0.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg
// Shared constants and types for the fetch-stage PC generator.
//   XLEN_DEF         default PC/address width
//   RESET_VECTOR_DEF default PC after reset
//   INST_BYTES_DEF   default PC increment per issued fetch
//   fetch_entry_t    in-flight queue entry {pc, stale}
package pc_fetch_pkg;

  localparam int                  XLEN_DEF         = 64;
  localparam logic [XLEN_DEF-1:0] RESET_VECTOR_DEF = '0;
  localparam int unsigned         INST_BYTES_DEF   = 4;

  // The pc field is sized for the widest supported PC; narrower cores
  // zero-extend on push and slice on read.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic                stale;
  } fetch_entry_t;

endpackage

// File: rtl/pc_inflight_fifo.sv
// pc_inflight_fifo
// In-order circular buffer of issued fetch PCs.
//   clk, rst_n   clock / asynchronous active-low reset
//   push         write push_entry at the tail (ignored when full)
//   push_entry   entry to write
//   pop          drop the head entry (ignored when empty)
//   mark_stale   set the stale bit of every stored entry
//   head         combinational view of the oldest entry
//   count        number of stored entries (0..DEPTH)
//   empty, full  occupancy flags
module pc_inflight_fifo
  import pc_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     mark_stale,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits match.
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        push_ok;
  logic        pop_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign head    = mem[rptr[AW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // The tail write is placed after the stale sweep so that, if both were
  // ever requested together, the freshly pushed entry keeps its own flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (mark_stale) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[i].stale <= 1'b1;
        end
      end
      if (push_ok) begin
        mem[wptr[AW-1:0]] <= push_entry;
        wptr              <= wptr + 1'b1;
      end
      if (pop_ok) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Fetch-stage program counter with request handshake and in-flight tracking.
//   clk, rst_n      clock / asynchronous active-low reset
//   stall           hold the PC and suppress new requests
//   redirect_valid  retarget the PC to redirect_pc this cycle
//   redirect_pc     new fetch target
//   req_valid       fetch request valid (independent of req_ready)
//   req_addr        fetch address (= current_pc)
//   req_ready       memory accepts the request
//   rsp_valid       one in-order memory response
//   rsp_pc_valid    response belongs to the live path
//   rsp_pc          PC of the response (queue head)
//   current_pc      architectural fetch PC
//   inflight_cnt    outstanding requests
//   misaligned      redirect target not a multiple of INST_BYTES
//   protocol_err    sticky: response seen with nothing outstanding
// XLEN must not exceed XLEN_DEF (queue entries are XLEN_DEF wide).
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int                 XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0]    RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int unsigned        INST_BYTES   = INST_BYTES_DEF,
  parameter int                 DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   req_valid,
  output logic [XLEN-1:0]        req_addr,
  input  logic                   req_ready,
  input  logic                   rsp_valid,
  output logic                   rsp_pc_valid,
  output logic [XLEN-1:0]        rsp_pc,
  output logic [XLEN-1:0]        current_pc,
  output logic [$clog2(DEPTH):0] inflight_cnt,
  output logic                   misaligned,
  output logic                   protocol_err
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic            fire;
  logic            pop;
  logic            fifo_empty;
  logic            fifo_full;
  logic            err_q;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  pc_inflight_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fire),
    .push_entry (push_entry),
    .pop        (pop),
    .mark_stale (redirect_valid),
    .head       (head),
    .count      (inflight_cnt),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  // req_valid deliberately ignores a same-cycle pop so it never depends on
  // rsp_valid; rst_n gating keeps it low throughout reset.
  assign req_valid = rst_n && !stall && !redirect_valid && !fifo_full;
  assign fire      = req_valid && req_ready;
  assign req_addr  = pc_q;
  assign current_pc = pc_q;

  assign push_entry.pc    = XLEN_DEF'(pc_q);
  assign push_entry.stale = 1'b0;

  // Responses drain the queue even during stall; a redirect in the same
  // cycle still pops the head but kills its validity.
  assign pop          = rsp_valid && !fifo_empty;
  assign rsp_pc       = head.pc[XLEN-1:0];
  assign rsp_pc_valid = rst_n && pop && !head.stale && !redirect_valid;

  assign misaligned   = redirect_valid && ((redirect_pc % XLEN'(INST_BYTES)) != '0);
  assign protocol_err = err_q;

  // Next-PC priority: redirect, then increment on an accepted request,
  // otherwise hold. The increment wraps naturally at 2^XLEN.
  always_comb begin
    pc_next = pc_q;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (fire) begin
      pc_next = pc_q + XLEN'(INST_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      err_q <= 1'b0;
    end else begin
      pc_q <= pc_next;
      if (rsp_valid && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// Directed self-checking bench for pc_fetch_unit. A second instance with a
// reset vector near the top of the address space exercises PC wrap-around.
module tb_pc_fetch_unit;

  localparam logic [63:0] WRAP_VECTOR = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        req_ready;
  logic        rsp_valid;

  logic        req_valid;
  logic [63:0] req_addr;
  logic        rsp_pc_valid;
  logic [63:0] rsp_pc;
  logic [63:0] current_pc;
  logic [2:0]  inflight_cnt;
  logic        misaligned;
  logic        protocol_err;

  logic        w_req_valid;
  logic [63:0] w_req_addr;
  logic        w_rsp_pc_valid;
  logic [63:0] w_rsp_pc;
  logic [63:0] w_current_pc;
  logic [2:0]  w_inflight_cnt;
  logic        w_misaligned;
  logic        w_protocol_err;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit #(
    .XLEN(64), .RESET_VECTOR(64'h0), .INST_BYTES(4), .DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_pc_valid(rsp_pc_valid), .rsp_pc(rsp_pc),
    .current_pc(current_pc), .inflight_cnt(inflight_cnt),
    .misaligned(misaligned), .protocol_err(protocol_err)
  );

  pc_fetch_unit #(
    .XLEN(64), .RESET_VECTOR(WRAP_VECTOR), .INST_BYTES(4), .DEPTH(4)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(w_req_valid), .req_addr(w_req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_pc_valid(w_rsp_pc_valid), .rsp_pc(w_rsp_pc),
    .current_pc(w_current_pc), .inflight_cnt(w_inflight_cnt),
    .misaligned(w_misaligned), .protocol_err(w_protocol_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic rv,
                               input logic [63:0] rpc, input logic rdy,
                               input logic rsp);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    req_ready      = rdy;
    rsp_valid      = rsp;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(0, 0, 64'h0, 0, 0);
    checkOutput("rst_pc", current_pc, 64'h0);
    checkOutput("rst_cnt", 64'(inflight_cnt), 64'd0);
    checkOutput("rst_req_valid", 64'(req_valid), 64'd0);
    checkOutput("rst_perr", 64'(protocol_err), 64'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;

    // 1: streaming fetch, responses two cycles behind requests
    doReset();
    checkOutput("rst_rsp_pc_valid", 64'(rsp_pc_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 64'h0, 1, (i >= 2));
      checkOutput("t1_req_valid", 64'(req_valid), 64'd1);
      checkOutput("t1_req_addr", req_addr, 64'(i * 4));
      if (i >= 2) begin
        checkOutput("t1_rsp_pc_valid", 64'(rsp_pc_valid), 64'd1);
        checkOutput("t1_rsp_pc", rsp_pc, 64'((i - 2) * 4));
      end
      tick();
      checkOutput("t1_cnt", 64'(inflight_cnt), (i == 0) ? 64'd1 : 64'd2);
    end

    // 2: stall at 0x10 while the two pending responses drain
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1, 0, 64'h0, 1, (j < 2));
      checkOutput("t2_req_valid", 64'(req_valid), 64'd0);
      if (j < 2) begin
        checkOutput("t2_rsp_pc_valid", 64'(rsp_pc_valid), 64'd1);
        checkOutput("t2_rsp_pc", rsp_pc, 64'(8 + 4 * j));
      end
      tick();
      checkOutput("t2_pc", current_pc, 64'h10);
      checkOutput("t2_cnt", 64'(inflight_cnt), (j == 0) ? 64'd1 : 64'd0);
    end

    // 3: redirect with three requests outstanding
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 64'h0, 1, 0);
      checkOutput("t3_req_addr", req_addr, 64'(i * 4));
      tick();
    end
    applyStimulus(0, 1, 64'h100, 1, 0);
    checkOutput("t3_redir_req_valid", 64'(req_valid), 64'd0);
    checkOutput("t3_misaligned", 64'(misaligned), 64'd0);
    tick();
    checkOutput("t3_pc", current_pc, 64'h100);
    checkOutput("t3_cnt", 64'(inflight_cnt), 64'd3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 64'h0, 0, 1);
      checkOutput("t3_stale_rsp", 64'(rsp_pc_valid), 64'd0);
      tick();
    end
    checkOutput("t3_drained", 64'(inflight_cnt), 64'd0);
    applyStimulus(0, 0, 64'h0, 1, 0);
    checkOutput("t3_new_req_addr", req_addr, 64'h100);
    tick();
    applyStimulus(0, 0, 64'h0, 0, 1);
    checkOutput("t3_live_rsp_valid", 64'(rsp_pc_valid), 64'd1);
    checkOutput("t3_live_rsp_pc", rsp_pc, 64'h100);
    tick();

    // 4: fill the queue, then a single response reopens one slot
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 64'h0, 1, 0);
      checkOutput("t4_req_valid", 64'(req_valid), 64'd1);
      tick();
    end
    applyStimulus(0, 0, 64'h0, 1, 0);
    checkOutput("t4_full_req_valid", 64'(req_valid), 64'd0);
    checkOutput("t4_full_cnt", 64'(inflight_cnt), 64'd4);
    checkOutput("t4_full_pc", current_pc, 64'h10);
    tick();
    applyStimulus(0, 0, 64'h0, 1, 1);
    checkOutput("t4_pop_req_valid", 64'(req_valid), 64'd0);
    checkOutput("t4_pop_rsp_pc", rsp_pc, 64'h0);
    tick();
    applyStimulus(0, 0, 64'h0, 1, 0);
    checkOutput("t4_reopen_req_valid", 64'(req_valid), 64'd1);
    checkOutput("t4_reopen_addr", req_addr, 64'h10);
    tick();
    checkOutput("t4_refull_cnt", 64'(inflight_cnt), 64'd4);

    // 5: redirect colliding with a live response, then an empty-queue response
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 64'h0, 1, 0);
      tick();
    end
    applyStimulus(0, 0, 64'h0, 0, 1);
    checkOutput("t5_first_rsp_valid", 64'(rsp_pc_valid), 64'd1);
    checkOutput("t5_first_rsp_pc", rsp_pc, 64'h0);
    tick();
    applyStimulus(0, 1, 64'h200, 0, 1);
    checkOutput("t5_killed_rsp_valid", 64'(rsp_pc_valid), 64'd0);
    checkOutput("t5_killed_rsp_pc", rsp_pc, 64'h4);
    tick();
    checkOutput("t5_cnt_after_kill", 64'(inflight_cnt), 64'd1);
    checkOutput("t5_pc", current_pc, 64'h200);
    applyStimulus(0, 0, 64'h0, 0, 1);
    checkOutput("t5_stale_rsp", 64'(rsp_pc_valid), 64'd0);
    tick();
    applyStimulus(0, 0, 64'h0, 0, 1);
    checkOutput("t5_empty_rsp_valid", 64'(rsp_pc_valid), 64'd0);
    checkOutput("t5_perr_before", 64'(protocol_err), 64'd0);
    tick();
    checkOutput("t5_perr_set", 64'(protocol_err), 64'd1);
    checkOutput("t5_empty_cnt", 64'(inflight_cnt), 64'd0);
    applyStimulus(0, 0, 64'h0, 0, 0);
    tick();
    checkOutput("t5_perr_sticky", 64'(protocol_err), 64'd1);
    applyStimulus(0, 1, 64'h102, 1, 0);
    checkOutput("t5_misaligned", 64'(misaligned), 64'd1);
    checkOutput("t5_misaligned_req_valid", 64'(req_valid), 64'd0);
    tick();
    checkOutput("t5_unmasked_pc", current_pc, 64'h102);

    // 6: asynchronous reset mid-cycle with three requests outstanding
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 64'h0, 1, 0);
      checkOutput("t6_req_addr", req_addr, 64'(64'h102 + 4 * k));
      tick();
    end
    checkOutput("t6_cnt_before", 64'(inflight_cnt), 64'd3);
    applyStimulus(0, 0, 64'h0, 0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_pc", current_pc, 64'h0);
    checkOutput("t6_async_cnt", 64'(inflight_cnt), 64'd0);
    checkOutput("t6_async_perr", 64'(protocol_err), 64'd0);
    checkOutput("t6_async_req_valid", 64'(req_valid), 64'd0);
    checkOutput("t6_async_rsp_pc_valid", 64'(rsp_pc_valid), 64'd0);
    checkOutput("t6_wrap_reset_pc", w_current_pc, WRAP_VECTOR);
    #2;
    rst_n = 1'b1;
    applyStimulus(0, 0, 64'h0, 1, 0);
    checkOutput("t6_restart_addr", req_addr, 64'h0);
    checkOutput("t6_wrap_req_addr", w_req_addr, WRAP_VECTOR);
    tick();
    checkOutput("t6_restart_pc", current_pc, 64'h4);
    checkOutput("t6_wrap_pc", w_current_pc, 64'h0);
    checkOutput("t6_perr_after", 64'(protocol_err), 64'd0);
    applyStimulus(0, 0, 64'h0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
